// File: rtl/nibble_sub_seq.sv
// Multi-cycle S-AES nibble substitution (forward/inverse S-box), LANES nibbles per cycle.
// Optional feature macro: NIBSUB_CNT_EN adds a 16-bit drained-word counter output.
module nibble_sub_seq #(
    parameter int WORD_W = 16,
    parameter int LANES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef NIBSUB_CNT_EN
    output logic [15:0]       word_cnt,
`endif
    output logic [WORD_W-1:0] out_data
);

    localparam int NIB    = WORD_W / 4;
    localparam int GROUPS = (LANES > 0) ? (NIB / LANES) : 1;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);

    // Reject illegal geometry at elaboration time.
    generate
        if ((WORD_W < 4) || (WORD_W % 4 != 0) || (LANES < 1) || (NIB % LANES != 0)) begin : g_bad_param
            $fatal(1, "nibble_sub_seq: illegal WORD_W/LANES combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x, input logic inv);
        logic [3:0] y;
        if (inv) begin
            case (x)
                4'h0: y = 4'hA;  4'h1: y = 4'h5;  4'h2: y = 4'h9;  4'h3: y = 4'hB;
                4'h4: y = 4'h1;  4'h5: y = 4'h7;  4'h6: y = 4'h8;  4'h7: y = 4'hF;
                4'h8: y = 4'h6;  4'h9: y = 4'h0;  4'hA: y = 4'h2;  4'hB: y = 4'h3;
                4'hC: y = 4'hC;  4'hD: y = 4'h4;  4'hE: y = 4'hD;  4'hF: y = 4'hE;
                default: y = 4'h0;
            endcase
        end else begin
            case (x)
                4'h0: y = 4'h9;  4'h1: y = 4'h4;  4'h2: y = 4'hA;  4'h3: y = 4'hB;
                4'h4: y = 4'hD;  4'h5: y = 4'h1;  4'h6: y = 4'h8;  4'h7: y = 4'h5;
                4'h8: y = 4'h6;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'h3;
                4'hC: y = 4'hC;  4'hD: y = 4'hE;  4'hE: y = 4'hF;  4'hF: y = 4'h7;
                default: y = 4'h0;
            endcase
        end
        return y;
    endfunction

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              inv_q, inv_d;
    logic [GW-1:0]     g_q, g_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              in_ready_q, in_ready_d;
    logic [WORD_W-1:0] sub_word_s;
`ifdef NIBSUB_CNT_EN
    logic [15:0]       word_cnt_q, word_cnt_d;
`endif

    // Substitute the current group of nibbles in the captured word.
    always_comb begin
        sub_word_s = word_q;
        for (int l = 0; l < LANES; l++) begin
            int idx;
            idx = int'(g_q) * LANES + l;
            sub_word_s[idx*4 +: 4] = sbox(word_q[idx*4 +: 4], inv_q);
        end
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        inv_d       = inv_q;
        g_d         = g_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    word_d     = in_data;
                    inv_d      = in_inv;
                    g_d        = '0;
                    in_ready_d = 1'b0;
                    state_d    = SUB;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            SUB: begin
                word_d = sub_word_s;
                // The last group exits directly, so g never wraps.
                if (g_q == G_LAST) begin
                    out_data_d  = sub_word_s;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    g_d = g_q + GW'(1);
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

`ifdef NIBSUB_CNT_EN
    // Drained-word counter, wraps naturally at 16 bits.
    always_comb begin
        if (out_valid_q && out_ready) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end else begin
            word_cnt_d = word_cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= 16'd0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

    // State and datapath registers; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            inv_q       <= 1'b0;
            g_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            inv_q       <= inv_d;
            g_q         <= g_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_nibble_sub_seq.sv
// Directed bench for nibble_sub_seq: LANES=1 instance (a_*) and LANES=4 instance (b_*).
module tb_nibble_sub_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_in_valid = 1'b0, a_in_inv = 1'b0, a_out_ready = 1'b1;
    logic [15:0] a_in_data = 16'h0000;
    logic        a_in_ready, a_out_valid;
    logic [15:0] a_out_data;
    logic        b_in_valid = 1'b0, b_in_inv = 1'b0, b_out_ready = 1'b1;
    logic [15:0] b_in_data = 16'h0000;
    logic        b_in_ready, b_out_valid;
    logic [15:0] b_out_data;
`ifdef NIBSUB_CNT_EN
    logic [15:0] a_word_cnt, b_word_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nibble_sub_seq #(.WORD_W(16), .LANES(1)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_inv(a_in_inv),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
`ifdef NIBSUB_CNT_EN
        .word_cnt(a_word_cnt),
`endif
        .out_data(a_out_data)
    );

    nibble_sub_seq #(.WORD_W(16), .LANES(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_inv(b_in_inv),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
`ifdef NIBSUB_CNT_EN
        .word_cnt(b_word_cnt),
`endif
        .out_data(b_out_data)
    );

    typedef struct {
        logic [15:0] data;
        logic        inv;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one word to a given instance (sel=0 -> a, 1 -> b) and check result and latency.
    task automatic run_word(input bit sel, input logic [15:0] d, input logic inv,
                            input logic [15:0] exp, input int exp_lat, input string name);
        int t;
        int lat;
        if (sel) begin b_in_data = d; b_in_inv = inv; b_in_valid = 1'b1; end
        else     begin a_in_data = d; a_in_inv = inv; a_in_valid = 1'b1; end
        t = 0;
        while (!(sel ? b_in_ready : a_in_ready) && t < 50) begin tick(); t++; end
        if (t >= 50) chk({name, " ready timeout"}, 32'd0, 32'd1);
        tick();
        // Scramble inputs after accept: they must have no effect.
        if (sel) begin b_in_valid = 1'b0; b_in_data = ~d; b_in_inv = ~inv; end
        else     begin a_in_valid = 1'b0; a_in_data = ~d; a_in_inv = ~inv; end
        lat = 0;
        while (!(sel ? b_out_valid : a_out_valid) && lat < 20) begin tick(); lat++; end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " data"}, 32'(sel ? b_out_data : a_out_data), 32'(exp));
        chk({name, " busy in_ready"}, 32'(sel ? b_in_ready : a_in_ready), 32'd0);
        tick();
        chk({name, " drained"}, 32'(sel ? b_out_valid : a_out_valid), 32'd0);
        chk({name, " idle in_ready"}, 32'(sel ? b_in_ready : a_in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        vecs[0]  = '{16'h9A0C, 1'b1, 16'h02AC};
        vecs[1]  = '{16'h02AC, 1'b0, 16'h9A0C};
        vecs[2]  = '{16'h3210, 1'b0, 16'hBA49};
        vecs[3]  = '{16'h7654, 1'b0, 16'h581D};
        vecs[4]  = '{16'hBA98, 1'b0, 16'h3026};
        vecs[5]  = '{16'hFEDC, 1'b0, 16'h7FEC};
        vecs[6]  = '{16'hBA49, 1'b1, 16'h3210};
        vecs[7]  = '{16'h581D, 1'b1, 16'h7654};
        vecs[8]  = '{16'h3026, 1'b1, 16'hBA98};
        vecs[9]  = '{16'h7FEC, 1'b1, 16'hFEDC};
        vecs[10] = '{16'h0000, 1'b0, 16'h9999};
        vecs[11] = '{16'hFFFF, 1'b1, 16'hEEEE};

        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("reset out_valid", 32'(a_out_valid), 32'd0);
        chk("reset out_data", 32'(a_out_data), 32'd0);
        chk("reset in_ready", 32'(a_in_ready), 32'd1);
        chk("reset b in_ready", 32'(b_in_ready), 32'd1);

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            run_word(1'b0, vecs[i].data, vecs[i].inv, vecs[i].exp, 4, $sformatf("vec%0d", i));
        end

        // Backpressure: hold result 5 cycles while a second word waits
        a_out_ready = 1'b0;
        a_in_data = 16'h9A0C; a_in_inv = 1'b1; a_in_valid = 1'b1;
        tick();
        a_in_data = 16'h02AC; a_in_inv = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 20) begin tick(); lat++; end
        chk("bp latency", 32'(lat), 32'd4);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp held data", 32'(a_out_data), 32'h02AC);
            chk("bp held valid", 32'(a_out_valid), 32'd1);
            chk("bp in_ready", 32'(a_in_ready), 32'd0);
        end
        a_out_ready = 1'b1;
        tick();
        chk("bp drain valid", 32'(a_out_valid), 32'd0);
        chk("bp drain in_ready", 32'(a_in_ready), 32'd1);
        tick();
        chk("bp second accepted", 32'(a_in_ready), 32'd0);
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 20) begin tick(); lat++; end
        chk("bp second latency", 32'(lat), 32'd4);
        chk("bp second data", 32'(a_out_data), 32'h9A0C);
        tick();

        // Reset in the second SUB cycle aborts the word
        a_in_data = 16'h1234; a_in_inv = 1'b0; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort out_valid", 32'(a_out_valid), 32'd0);
        chk("abort out_data", 32'(a_out_data), 32'd0);
        chk("abort in_ready", 32'(a_in_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (a_out_valid) seen++;
        end
        chk("abort no result", 32'(seen), 32'd0);
        run_word(1'b0, 16'h9A0C, 1'b1, 16'h02AC, 4, "post-abort");

        // LANES=4: single SUB cycle, three drained words
        run_word(1'b1, 16'h0123, 1'b1, 16'hA59B, 1, "lanes4 w0");
        run_word(1'b1, 16'h3210, 1'b0, 16'hBA49, 1, "lanes4 w1");
        run_word(1'b1, 16'hFEDC, 1'b0, 16'h7FEC, 1, "lanes4 w2");
`ifdef NIBSUB_CNT_EN
        chk("lanes4 word_cnt", 32'(b_word_cnt), 32'd3);
        chk("lanes1 word_cnt", 32'(a_word_cnt), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
